regfile_wb_arbiter: RTL and testbench

- Shares the single write port of the 32x64-bit register file among NREQ write-back producers (ALU, load unit, multicycle unit).
- Uses round-robin arbitration and a valid/ready handshake per requester.
- Maintains a pending-write scoreboard (one busy bit per register) and a combinational read-after-write stall flag for the issue stage.
- Drives the register file's write, write-address and data-in inputs from a registered output stage.

---
 rtl/regfile_wb_arbiter_if.sv | 26 ++
 rtl/regfile_wb_arbiter.sv | 124 ++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// Write-back request bus between the producers and the register-file arbiter.
// One valid/ready pair per requester, with address and data packed per requester.
interface regfile_wb_arbiter_if #(
   parameter int NREQ   = 3,
   parameter int DATA_W = 64,
   parameter int ADDR_W = 5
);
   logic [NREQ-1:0]        req_valid;
   logic [NREQ-1:0]        req_ready;
   logic [NREQ*ADDR_W-1:0] req_addr;
   logic [NREQ*DATA_W-1:0] req_data;

   modport master (
      output req_valid,
      output req_addr,
      output req_data,
      input  req_ready
   );

   modport slave (
      input  req_valid,
      input  req_addr,
      input  req_data,
      output req_ready
   );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter for the register file write port, with a registered write stage
// and a pending-write scoreboard that raises a read-after-write stall for issue.
module regfile_wb_arbiter #(
   parameter int NREQ   = 3,
   parameter int DATA_W = 64,
   parameter int ADDR_W = 5,
   parameter int NREGS  = 32,
   localparam int GID_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic                 clk,
   input  logic                 rst,
   regfile_wb_arbiter_if.slave  wb,
   output logic                 rf_write_o,
   output logic [ADDR_W-1:0]    rf_addr_o,
   output logic [DATA_W-1:0]    rf_data_o,
   output logic [GID_W-1:0]     grant_id_o,
   input  logic                 issue_valid_i,
   input  logic [ADDR_W-1:0]    issue_rd_i,
   input  logic [ADDR_W-1:0]    rs1_i,
   input  logic [ADDR_W-1:0]    rs2_i,
   output logic [NREGS-1:0]     busy_mask_o,
   output logic                 stall_o
);

   logic [GID_W-1:0]  ptr_q, ptr_d;
   logic              rf_write_q, rf_write_d;
   logic [ADDR_W-1:0] rf_addr_q, rf_addr_d;
   logic [DATA_W-1:0] rf_data_q, rf_data_d;
   logic [GID_W-1:0]  grant_id_q, grant_id_d;
   logic [NREGS-1:0]  busy_q, busy_d;

   logic              found;
   logic              xfer;
   logic [GID_W-1:0]  win_idx;
   logic [NREQ-1:0]   grant_oh;
   logic [ADDR_W-1:0] win_addr;
   logic [DATA_W-1:0] win_data;

   // Scan requesters starting at the pointer; the first valid one after wrap-around wins.
   always_comb begin
      int idx;
      found   = 1'b0;
      win_idx = '0;
      idx     = 0;
      for (int k = 0; k < NREQ; k++) begin
         idx = int'(ptr_q) + k;
         if (idx >= NREQ) begin
            idx = idx - NREQ;
         end
         if (!found && wb.req_valid[idx]) begin
            found   = 1'b1;
            win_idx = GID_W'(idx);
         end
      end
   end

   // Ready is held low during reset so no requester believes it was accepted.
   always_comb begin
      xfer     = found && !rst;
      grant_oh = '0;
      win_addr = '0;
      win_data = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (win_idx == GID_W'(i)) begin
            grant_oh[i] = xfer;
            win_addr    = wb.req_addr[i*ADDR_W +: ADDR_W];
            win_data    = wb.req_data[i*DATA_W +: DATA_W];
         end
      end
   end

   assign wb.req_ready = grant_oh;

   always_comb begin
      int nxt;
      nxt        = int'(win_idx) + 1;
      if (nxt >= NREQ) begin
         nxt = 0;
      end
      ptr_d      = xfer ? GID_W'(nxt) : ptr_q;
      rf_write_d = xfer && (win_addr != '0);
      rf_addr_d  = xfer ? win_addr : rf_addr_q;
      rf_data_d  = xfer ? win_data : rf_data_q;
      grant_id_d = xfer ? win_idx  : grant_id_q;
   end

   // Clear before set so a newly issued producer keeps its register marked busy.
   always_comb begin
      busy_d = busy_q;
      if (xfer) begin
         busy_d[win_addr] = 1'b0;
      end
      if (issue_valid_i && (issue_rd_i != '0)) begin
         busy_d[issue_rd_i] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q      <= '0;
         rf_write_q <= 1'b0;
         rf_addr_q  <= '0;
         rf_data_q  <= '0;
         grant_id_q <= '0;
         busy_q     <= '0;
      end else begin
         ptr_q      <= ptr_d;
         rf_write_q <= rf_write_d;
         rf_addr_q  <= rf_addr_d;
         rf_data_q  <= rf_data_d;
         grant_id_q <= grant_id_d;
         busy_q     <= busy_d;
      end
   end

   assign rf_write_o  = rf_write_q;
   assign rf_addr_o   = rf_addr_q;
   assign rf_data_o   = rf_data_q;
   assign grant_id_o  = grant_id_q;
   assign busy_mask_o = busy_q;
   assign stall_o     = ((rs1_i != '0) && busy_q[rs1_i]) || ((rs2_i != '0) && busy_q[rs2_i]);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Testbench for regfile_wb_arbiter: directed scenarios followed by randomized traffic
// compared against a transaction-level model of arbitration, write stage and scoreboard.
module tb_regfile_wb_arbiter;

   localparam int NREQ   = 3;
   localparam int DATA_W = 64;
   localparam int ADDR_W = 5;
   localparam int NREGS  = 32;

   logic              clk = 1'b0;
   logic              rst;
   logic              rf_write;
   logic [ADDR_W-1:0] rf_addr;
   logic [DATA_W-1:0] rf_data;
   logic [1:0]        grant_id;
   logic              issue_valid;
   logic [ADDR_W-1:0] issue_rd;
   logic [ADDR_W-1:0] rs1;
   logic [ADDR_W-1:0] rs2;
   logic [NREGS-1:0]  busy_mask;
   logic              stall;

   int checks = 0;
   int errors = 0;

   regfile_wb_arbiter_if #(.NREQ(NREQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) wb ();

   regfile_wb_arbiter #(.NREQ(NREQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREGS(NREGS)) dut (
      .clk           (clk),
      .rst           (rst),
      .wb            (wb),
      .rf_write_o    (rf_write),
      .rf_addr_o     (rf_addr),
      .rf_data_o     (rf_data),
      .grant_id_o    (grant_id),
      .issue_valid_i (issue_valid),
      .issue_rd_i    (issue_rd),
      .rs1_i         (rs1),
      .rs2_i         (rs2),
      .busy_mask_o   (busy_mask),
      .stall_o       (stall)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      wb.req_valid = '0;
      wb.req_addr  = '0;
      wb.req_data  = '0;
      issue_valid  = 1'b0;
      issue_rd     = '0;
      rs1          = '0;
      rs2          = '0;
   endtask

   task automatic set_req(input int i, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      wb.req_addr[i*ADDR_W +: ADDR_W] = a;
      wb.req_data[i*DATA_W +: DATA_W] = d;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle_inputs();
      #2;
      checks += 6;
      if (rf_write !== 1'b0) begin errors++; $display("[TB] FAIL reset_rf_write got %b exp 0", rf_write); end
      if (rf_addr !== '0) begin errors++; $display("[TB] FAIL reset_rf_addr got %h exp 0", rf_addr); end
      if (rf_data !== '0) begin errors++; $display("[TB] FAIL reset_rf_data got %h exp 0", rf_data); end
      if (grant_id !== 2'd0) begin errors++; $display("[TB] FAIL reset_grant_id got %0d exp 0", grant_id); end
      if (busy_mask !== '0) begin errors++; $display("[TB] FAIL reset_busy got %h exp 0", busy_mask); end
      if (wb.req_ready !== 3'b000) begin errors++; $display("[TB] FAIL reset_ready got %b exp 000", wb.req_ready); end
      wb.req_valid = 3'b111;
      #1;
      checks++;
      if (wb.req_ready !== 3'b000) begin errors++; $display("[TB] FAIL reset_ready_gated got %b exp 000", wb.req_ready); end
      wb.req_valid = '0;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_single();
      set_req(1, 5'd5, 64'hDEAD);
      wb.req_valid = 3'b010;
      #1;
      checks++;
      if (wb.req_ready !== 3'b010) begin errors++; $display("[TB] FAIL single_ready got %b exp 010", wb.req_ready); end
      tick();
      wb.req_valid = '0;
      checks += 4;
      if (rf_write !== 1'b1) begin errors++; $display("[TB] FAIL single_write got %b exp 1", rf_write); end
      if (rf_addr !== 5'd5) begin errors++; $display("[TB] FAIL single_addr got %0d exp 5", rf_addr); end
      if (rf_data !== 64'hDEAD) begin errors++; $display("[TB] FAIL single_data got %h exp dead", rf_data); end
      if (grant_id !== 2'd1) begin errors++; $display("[TB] FAIL single_gid got %0d exp 1", grant_id); end
      tick();
      checks += 3;
      if (rf_write !== 1'b0) begin errors++; $display("[TB] FAIL idle_write got %b exp 0", rf_write); end
      if (rf_addr !== 5'd5) begin errors++; $display("[TB] FAIL idle_addr_hold got %0d exp 5", rf_addr); end
      if (grant_id !== 2'd1) begin errors++; $display("[TB] FAIL idle_gid_hold got %0d exp 1", grant_id); end
   endtask

   task automatic test_x0_write();
      set_req(2, 5'd0, 64'h1);
      wb.req_valid = 3'b100;
      #1;
      checks++;
      if (wb.req_ready !== 3'b100) begin errors++; $display("[TB] FAIL x0_ready got %b exp 100", wb.req_ready); end
      tick();
      wb.req_valid = '0;
      checks += 3;
      if (rf_write !== 1'b0) begin errors++; $display("[TB] FAIL x0_write got %b exp 0", rf_write); end
      if (grant_id !== 2'd2) begin errors++; $display("[TB] FAIL x0_gid got %0d exp 2", grant_id); end
      if (rf_data !== 64'h1) begin errors++; $display("[TB] FAIL x0_data got %h exp 1", rf_data); end
   endtask

   task automatic test_round_robin();
      for (int i = 0; i < NREQ; i++) set_req(i, ADDR_W'(i + 1), 64'h100 + 64'(i));
      wb.req_valid = 3'b111;
      for (int k = 0; k < 6; k++) begin
         #1;
         checks++;
         if (wb.req_ready !== 3'(1 << (k % 3))) begin
            errors++; $display("[TB] FAIL rr_ready[%0d] got %b exp %b", k, wb.req_ready, 3'(1 << (k % 3)));
         end
         tick();
         checks += 3;
         if (rf_write !== 1'b1) begin errors++; $display("[TB] FAIL rr_write[%0d] got %b exp 1", k, rf_write); end
         if (grant_id !== 2'(k % 3)) begin errors++; $display("[TB] FAIL rr_gid[%0d] got %0d exp %0d", k, grant_id, k % 3); end
         if (rf_addr !== ADDR_W'(k % 3 + 1)) begin errors++; $display("[TB] FAIL rr_addr[%0d] got %0d exp %0d", k, rf_addr, k % 3 + 1); end
      end
      wb.req_valid = '0;
      tick();
      checks++;
      if (rf_write !== 1'b0) begin errors++; $display("[TB] FAIL rr_end_write got %b exp 0", rf_write); end
   endtask

   task automatic test_scoreboard();
      issue_valid = 1'b1;
      issue_rd    = 5'd7;
      tick();
      issue_valid = 1'b0;
      rs1         = 5'd7;
      #1;
      checks += 2;
      if (busy_mask !== 32'h80) begin errors++; $display("[TB] FAIL sb_set got %h exp 80", busy_mask); end
      if (stall !== 1'b1) begin errors++; $display("[TB] FAIL sb_stall got %b exp 1", stall); end
      set_req(0, 5'd7, 64'h77);
      wb.req_valid = 3'b001;
      tick();
      wb.req_valid = '0;
      #1;
      checks += 2;
      if (busy_mask !== 32'h0) begin errors++; $display("[TB] FAIL sb_clear got %h exp 0", busy_mask); end
      if (stall !== 1'b0) begin errors++; $display("[TB] FAIL sb_unstall got %b exp 0", stall); end
      issue_valid = 1'b1;
      issue_rd    = 5'd0;
      tick();
      issue_valid = 1'b0;
      rs1         = 5'd0;
      checks++;
      if (busy_mask !== 32'h0) begin errors++; $display("[TB] FAIL sb_x0 got %h exp 0", busy_mask); end
   endtask

   task automatic test_set_clear();
      issue_valid = 1'b1;
      issue_rd    = 5'd9;
      tick();
      set_req(2, 5'd9, 64'h99);
      wb.req_valid = 3'b100;
      tick();
      wb.req_valid = '0;
      rs2          = 5'd9;
      #1;
      checks += 2;
      if (busy_mask !== 32'h200) begin errors++; $display("[TB] FAIL sc_same got %h exp 200", busy_mask); end
      if (stall !== 1'b1) begin errors++; $display("[TB] FAIL sc_stall got %b exp 1", stall); end
      issue_rd = 5'd10;
      tick();
      issue_rd = 5'd9;
      set_req(2, 5'd10, 64'hAA);
      wb.req_valid = 3'b100;
      tick();
      wb.req_valid = '0;
      issue_valid  = 1'b0;
      rs2          = 5'd0;
      checks++;
      if (busy_mask !== 32'h200) begin errors++; $display("[TB] FAIL sc_diff got %h exp 200", busy_mask); end
   endtask

   task automatic test_async_reset();
      set_req(2, 5'd9, 64'h9);
      wb.req_valid = 3'b100;
      issue_valid  = 1'b1;
      for (int r = 4; r < 8; r++) begin
         issue_rd = ADDR_W'(r);
         tick();
         wb.req_valid = '0;
      end
      issue_valid = 1'b0;
      for (int i = 0; i < NREQ; i++) set_req(i, ADDR_W'(i + 1), 64'h500 + 64'(i));
      wb.req_valid = 3'b111;
      tick();
      checks += 2;
      if (busy_mask !== 32'hF0) begin errors++; $display("[TB] FAIL ar_pre_busy got %h exp f0", busy_mask); end
      if (rf_write !== 1'b1) begin errors++; $display("[TB] FAIL ar_pre_write got %b exp 1", rf_write); end
      #2;
      rst = 1'b1;
      #1;
      checks += 3;
      if (rf_write !== 1'b0) begin errors++; $display("[TB] FAIL ar_write got %b exp 0", rf_write); end
      if (busy_mask !== '0) begin errors++; $display("[TB] FAIL ar_busy got %h exp 0", busy_mask); end
      if (wb.req_ready !== 3'b000) begin errors++; $display("[TB] FAIL ar_ready got %b exp 000", wb.req_ready); end
      tick();
      rst = 1'b0;
      #1;
      checks++;
      if (wb.req_ready !== 3'b001) begin errors++; $display("[TB] FAIL ar_first_ready got %b exp 001", wb.req_ready); end
      tick();
      wb.req_valid = '0;
      checks += 2;
      if (grant_id !== 2'd0) begin errors++; $display("[TB] FAIL ar_first_gid got %0d exp 0", grant_id); end
      if (rf_addr !== 5'd1) begin errors++; $display("[TB] FAIL ar_first_addr got %0d exp 1", rf_addr); end
   endtask

   task automatic test_random();
      bit                pv [NREQ];
      logic [ADDR_W-1:0] pa [NREQ];
      logic [DATA_W-1:0] pd [NREQ];
      bit   [NREGS-1:0]  mbusy;
      int                mptr, win;
      logic              exp_we;
      logic [ADDR_W-1:0] last_a;
      logic [DATA_W-1:0] last_d;
      int                last_g;
      logic [NREQ-1:0]   exp_ready;
      logic              exp_stall;
      rst = 1'b1;
      idle_inputs();
      tick();
      rst = 1'b0;
      mbusy = '0; mptr = 0; last_a = '0; last_d = '0; last_g = 0;
      for (int i = 0; i < NREQ; i++) begin pv[i] = 0; pa[i] = '0; pd[i] = '0; end
      for (int c = 0; c < 300; c++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!pv[i] && $urandom_range(0, 1) == 1) begin
               pv[i] = 1;
               pa[i] = ($urandom_range(0, 7) == 0) ? '0 : ADDR_W'($urandom_range(0, NREGS - 1));
               pd[i] = {$urandom, $urandom};
            end
            wb.req_valid[i] = pv[i];
            set_req(i, pa[i], pd[i]);
         end
         issue_valid = ($urandom_range(0, 2) == 0);
         issue_rd    = ADDR_W'($urandom_range(0, NREGS - 1));
         rs1         = ADDR_W'($urandom_range(0, NREGS - 1));
         rs2         = ADDR_W'($urandom_range(0, NREGS - 1));
         #1;
         win = -1;
         for (int k = 0; k < NREQ; k++) begin
            if (win < 0 && pv[(mptr + k) % NREQ]) win = (mptr + k) % NREQ;
         end
         exp_ready = (win >= 0) ? NREQ'(1 << win) : '0;
         exp_stall = (rs1 != 0 && mbusy[rs1]) || (rs2 != 0 && mbusy[rs2]);
         checks += 2;
         if (wb.req_ready !== exp_ready) begin errors++; $display("[TB] FAIL rnd_ready[%0d] got %b exp %b", c, wb.req_ready, exp_ready); end
         if (stall !== exp_stall) begin errors++; $display("[TB] FAIL rnd_stall[%0d] got %b exp %b", c, stall, exp_stall); end
         tick();
         exp_we = 1'b0;
         if (win >= 0) begin
            exp_we = (pa[win] != 0);
            last_a = pa[win];
            last_d = pd[win];
            last_g = win;
            mbusy[pa[win]] = 1'b0;
            pv[win] = 0;
            mptr = (win + 1) % NREQ;
         end
         if (issue_valid && issue_rd != 0) mbusy[issue_rd] = 1'b1;
         checks += 5;
         if (rf_write !== exp_we) begin errors++; $display("[TB] FAIL rnd_write[%0d] got %b exp %b", c, rf_write, exp_we); end
         if (rf_addr !== last_a) begin errors++; $display("[TB] FAIL rnd_addr[%0d] got %0d exp %0d", c, rf_addr, last_a); end
         if (rf_data !== last_d) begin errors++; $display("[TB] FAIL rnd_data[%0d] got %h exp %h", c, rf_data, last_d); end
         if (grant_id !== 2'(last_g)) begin errors++; $display("[TB] FAIL rnd_gid[%0d] got %0d exp %0d", c, grant_id, last_g); end
         if (busy_mask !== mbusy) begin errors++; $display("[TB] FAIL rnd_busy[%0d] got %h exp %h", c, busy_mask, mbusy); end
      end
      idle_inputs();
   endtask

   initial begin
      test_reset();
      test_single();
      test_x0_write();
      test_round_robin();
      test_scoreboard();
      test_set_clear();
      test_async_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
